// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the default frame width,
// used by both the SPI slave receiver and the SPI master controller.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous bit, with a selectable
// reset level so idle-high (chip select) and idle-low lines both reset
// to their inactive value.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through STAGES flops; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{rst_val}};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, giving a true shift chain.
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: receives MSB-first words on mosi and returns tx_data on
// miso, supporting back-to-back words within one chip-select period.
// Optional feature: define SPI_SLAVE_ECHO_EN to load every word after the
// first in a frame from the previously received word (loopback).
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              spi_scl,
  input  logic              spi_cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic scl_s, cs_s, mosi_s;
  logic scl_d, cs_d;
  logic scl_rise, scl_fall, cs_rise, cs_fall;

  spi_state_e        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, load_word;
  logic              miso_q;
  logic              last_rise;
  logic              do_load, do_sample, do_drive, word_done, abort;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(spi_clk), .rst_n(reset), .rst_val(1'b0), .d(spi_scl), .q(scl_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(spi_clk), .rst_n(reset), .rst_val(1'b1), .d(spi_cs), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(spi_clk), .rst_n(reset), .rst_val(1'b0), .d(mosi), .q(mosi_s)
  );

  // Delayed copies of the synchronized lines for edge detection.
  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) begin
      scl_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      scl_d <= scl_s;
      cs_d  <= cs_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign last_rise = scl_rise && (bit_cnt == CNT_W'(DATA_W - 1));

`ifdef SPI_SLAVE_ECHO_EN
  // Later words in a frame echo the word just received.
  assign load_word = (state == LOAD) ? rx_data : tx_data;
`else
  assign load_word = tx_data;
`endif

  // State register.
  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt = state;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          do_load   = 1'b1;
        end
      end
      SHIFT: begin
        do_sample = scl_rise;
        if (last_rise) begin
          // A word that completes together with cs rise still counts.
          word_done = 1'b1;
          state_nxt = cs_rise ? IDLE : LOAD;
        end else if (cs_rise) begin
          state_nxt = IDLE;
          abort     = (bit_cnt != '0) || scl_rise;
        end else if (scl_fall && (bit_cnt != '0)) begin
          // The fall right after a load (counter 0) must not shift away
          // the freshly presented MSB.
          do_drive = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = cs_rise ? IDLE : SHIFT;
        do_load   = ~cs_rise;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter, received word and status pulses.
  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (do_load) begin
        tx_sr   <= load_word;
        bit_cnt <= '0;
        miso_q  <= load_word[DATA_W-1];
      end
      if (do_sample) begin
        rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (word_done) begin
        rx_data  <= {rx_sr[DATA_W-2:0], mosi_s};
        rx_valid <= 1'b1;
      end
      if (do_drive) begin
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        miso_q <= tx_sr[DATA_W-2];
      end
      if (abort) frame_err <= 1'b1;
      if (state_nxt == IDLE) miso_q <= 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign miso = miso_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven single-word frames plus
// hand-written back-to-back, echo, abort, reset and simultaneous-edge cases.
// Received words are checked through a scoreboard queue.
module tb_spi_slave_rx;

  localparam int HALF = 60;  // scl half period: 6 spi_clk periods

  logic       spi_clk = 1'b0;
  logic       reset;
  logic       spi_scl;
  logic       spi_cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         n_vec  = 0;
  int         n_err  = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] mosi_w;
    logic [7:0] tx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .spi_clk  (spi_clk),
    .reset    (reset),
    .spi_scl  (spi_scl),
    .spi_cs   (spi_cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer and frame_err counter, sampled on the falling edge.
  always @(negedge spi_clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected rx_valid", 1, 0);
      else                   check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Master shifts nbits of w MSB-first; optionally raises cs with the last rise.
  task automatic xfer(input logic [7:0] w, input int nbits, input bit cs_on_last,
                      output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      #HALF;
      got = {got[6:0], miso};
      spi_scl = 1'b1;
      if (cs_on_last && i == nbits - 1) spi_cs = 1'b1;
      #HALF;
      spi_scl = 1'b0;
    end
  endtask

  task automatic end_frame();
    #HALF;
    spi_cs = 1'b1;
    #(2*HALF);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge spi_clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] g1, g2;
    int         fe_before;

    vecs[0] = '{8'h9a, 8'h5c, 8'h5c};
    vecs[1] = '{8'hff, 8'h00, 8'h00};
    vecs[2] = '{8'h00, 8'hff, 8'hff};
    vecs[3] = '{8'h3c, 8'ha5, 8'ha5};

    reset = 1'b0; spi_cs = 1'b1; spi_scl = 1'b0; mosi = 1'b0; tx_data = '0;
    #33;
    @(negedge spi_clk);
    check("reset rx_data",   rx_data,   0);
    check("reset rx_valid",  rx_valid,  0);
    check("reset frame_err", frame_err, 0);
    check("reset busy",      busy,      0);
    check("reset miso",      miso,      0);
    reset = 1'b1;
    repeat (5) @(posedge spi_clk);
    #3;

    // Single-word frames from the table.
    for (int v = 0; v < 4; v++) begin
      tx_data = vecs[v].tx;
      spi_cs  = 1'b0;
      exp_q.push_back(vecs[v].mosi_w);
      xfer(vecs[v].mosi_w, 8, 1'b0, g1);
      end_frame();
      drain("single word drain");
      check("single word miso", g1, vecs[v].exp_miso);
      @(negedge spi_clk);
      check("single word rx_data", rx_data, vecs[v].mosi_w);
      check("single word busy", busy, 0);
    end
    check("no frame_err after singles", fe_cnt, 0);

    // Back-to-back 8'h12, 8'h34.
    @(negedge spi_clk);
    tx_data = 8'h66;
    spi_cs  = 1'b0;
    exp_q.push_back(8'h12);
    xfer(8'h12, 8, 1'b0, g1);
    exp_q.push_back(8'h34);
    xfer(8'h34, 8, 1'b0, g2);
    end_frame();
    drain("b2b drain");
    check("b2b miso word1", g1, 8'h66);
`ifdef SPI_SLAVE_ECHO_EN
    check("b2b miso word2", g2, 8'h12);
`else
    check("b2b miso word2", g2, 8'h66);
`endif
    check("b2b no frame_err", fe_cnt, 0);

    // Echo pattern: 8'ha5 then 8'h00 with tx_data 8'hff.
    @(negedge spi_clk);
    tx_data = 8'hff;
    spi_cs  = 1'b0;
    exp_q.push_back(8'ha5);
    xfer(8'ha5, 8, 1'b0, g1);
    exp_q.push_back(8'h00);
    xfer(8'h00, 8, 1'b0, g2);
    end_frame();
    drain("echo drain");
    check("echo miso word1", g1, 8'hff);
`ifdef SPI_SLAVE_ECHO_EN
    check("echo miso word2", g2, 8'ha5);
`else
    check("echo miso word2", g2, 8'hff);
`endif

    // Abort after 5 bits.
    @(negedge spi_clk);
    tx_data   = 8'h5c;
    fe_before = fe_cnt;
    spi_cs    = 1'b0;
    xfer(8'hb7, 5, 1'b0, g1);
    #HALF;
    spi_cs = 1'b1;
    for (int i = 0; i < 50 && fe_cnt == fe_before; i++) @(negedge spi_clk);
    check("abort frame_err pulse", fe_cnt, fe_before + 1);
    @(negedge spi_clk);
    check("abort busy", busy, 0);
    check("abort rx_data kept", rx_data, 8'h00);
    check("abort miso idle", miso, 0);
    #(2*HALF);
    check("abort single pulse", fe_cnt, fe_before + 1);

    // Reset mid-word, then a fresh 8'hc3 frame.
    @(negedge spi_clk);
    fe_before = fe_cnt;
    spi_cs    = 1'b0;
    xfer(8'hff, 3, 1'b0, g1);
    reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset rx_data", rx_data, 0);
    spi_cs = 1'b1;
    #50;
    reset = 1'b1;
    #100;
    @(negedge spi_clk);
    tx_data = 8'h3e;
    spi_cs  = 1'b0;
    exp_q.push_back(8'hc3);
    xfer(8'hc3, 8, 1'b0, g1);
    end_frame();
    drain("post-reset drain");
    check("post-reset miso", g1, 8'h3e);
    check("post-reset rx_data", rx_data, 8'hc3);
    check("post-reset no frame_err", fe_cnt, fe_before);

    // cs rise coincident with the 8th scl rise.
    @(negedge spi_clk);
    tx_data = 8'h81;
    spi_cs  = 1'b0;
    exp_q.push_back(8'h6e);
    xfer(8'h6e, 8, 1'b1, g1);
    #(2*HALF);
    drain("simultaneous drain");
    @(negedge spi_clk);
    check("simultaneous miso", g1, 8'h81);
    check("simultaneous rx_data", rx_data, 8'h6e);
    check("simultaneous no frame_err", fe_cnt, fe_before);
    check("simultaneous busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the frame width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on spi_scl, spi_cs and mosi.
REQ-003 SHALL have port spi_clk, input, 1 bit: the single system clock; every flop is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_scl, input, 1 bit: serial clock from the master, asynchronous to spi_clk.
REQ-006 SHALL have port spi_cs, input, 1 bit: active-low chip select from the master.
REQ-007 SHALL have port mosi, input, 1 bit: serial data from the master, MSB first.
REQ-008 SHALL have port miso, output, 1 bit: serial data to the master, MSB first.
REQ-009 SHALL have port tx_data, input, DATA_W bits: response word, sampled at frame load.
REQ-010 SHALL have port rx_data, output, DATA_W bits: last completely received word.
REQ-011 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when spi_cs deasserts mid-word.
REQ-013 SHALL have port busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-014 SHALL operate in SPI mode 0: sample mosi on the synchronized spi_scl rising edge, and update miso on its falling edge.
REQ-015 SHALL detect spi_scl and spi_cs edges by comparing the last synchronizer stage with one extra registered copy; raw inputs SHALL NOT be used in logic.
REQ-016 SHALL implement three states: IDLE, SHIFT and LOAD.
REQ-017 In IDLE, a detected spi_cs fall SHALL go to SHIFT, load tx_data into the tx shift register, clear the bit counter and drive miso with tx_data[DATA_W-1] in the same cycle.
REQ-018 In SHIFT, each scl rise SHALL shift mosi into the rx register LSB and increment the bit counter; each scl fall SHALL shift the tx register and put the next bit on miso.
REQ-019 On the DATA_W-th scl rise, the block SHALL enter LOAD; rx_data and rx_valid SHALL update on the next spi_clk cycle.
REQ-020 LOAD SHALL last exactly one cycle: it reloads tx_data, clears the counter and returns to SHIFT, supporting back-to-back words within one spi_cs low period.
REQ-021 In SHIFT, an spi_cs rise with counter 0 SHALL return to IDLE silently; with counter 1..DATA_W-1 it SHALL pulse frame_err, discard the partial word (rx_data unchanged, no rx_valid) and return to IDLE.
REQ-022 If the spi_cs rise and the DATA_W-th scl rise are detected in the same cycle, the word SHALL complete (rx_valid pulses, no frame_err) and the next state SHALL be IDLE.
REQ-023 miso SHALL be 0 whenever the state is IDLE.
REQ-024 The bit counter SHALL be $clog2(DATA_W)+1 bits wide and SHALL never wrap; scl edges in IDLE SHALL be ignored.
REQ-025 Correct operation SHALL require an spi_scl period of at least 8 spi_clk periods.

Reset
REQ-026 With reset low, the block SHALL asynchronously clear: state to IDLE, rx_data to 0, rx_valid, frame_err, busy and miso to 0, synchronizers and edge registers to their idle levels (spi_cs 1, spi_scl 0).
REQ-027 Reset mid-word SHALL drop the partial word with no pulses; after release, the block SHALL wait for a fresh spi_cs fall.

Configuration
REQ-028 With SPI_SLAVE_ECHO_EN defined, every word after the first in a frame SHALL be loaded from the previous rx_data instead of tx_data (loopback); the first word SHALL still come from tx_data.
REQ-029 Without SPI_SLAVE_ECHO_EN, all loads SHALL use tx_data and no echo logic SHALL be synthesized.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum (IDLE/SHIFT/LOAD) and the default DATA_W constant, shared with the SPI master controller.
REQ-031 A sub-module spi_sync SHALL implement one parameterized SYNC_STAGES-deep synchronizer with a reset value input, instantiated three times.

Verification
REQ-032 The bench SHALL cover a single word: master sends 8'h9a with tx_data=8'h5c, giving rx_data=8'h9a, one rx_valid pulse and miso bits 0,1,0,1,1,1,0,0.
REQ-033 The bench SHALL cover back-to-back words: 8'h12 then 8'h34 in one spi_cs low period, giving two rx_valid pulses with 8'h12 then 8'h34 and no frame_err.
REQ-034 The bench SHALL cover an abort: spi_cs rises after 5 bits, giving one frame_err pulse, rx_data unchanged and busy low on the next cycle.
REQ-035 The bench SHALL cover reset mid-word: reset low after 3 bits, then a full 8'hc3 frame, giving rx_data=8'hc3 and no spurious pulses.
REQ-036 With SPI_SLAVE_ECHO_EN defined, the bench SHALL send 8'ha5 then 8'h00 with tx_data=8'hff, giving miso=8'hff on word 1 and 8'ha5 on word 2.
REQ-037 The bench SHALL cover the simultaneous edge: spi_cs rise coinciding with the 8th scl rise, giving rx_valid and no frame_err.
